alu_unit: RTL

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_unit_if.sv | 36 +++
 rtl/alu_unit.sv | 111 +++++++++++
 2 files changed

// File: rtl/alu_unit_if.sv
// Dispatch/result bundle between reservation station and ALU.
// The master offers operations; the slave (ALU) broadcasts results.
interface alu_unit_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 busy_in;
  logic [3:0]           opcode_in;
  logic [31:0]          lhs_in;
  logic [31:0]          rhs_in;
  logic [ROB_WIDTH-1:0] rd_tag_in;
  logic                 done_out;
  logic [31:0]          value_out;
  logic [ROB_WIDTH-1:0] tag_out;

  modport master (
    output busy_in,
    output opcode_in,
    output lhs_in,
    output rhs_in,
    output rd_tag_in,
    input  done_out,
    input  value_out,
    input  tag_out
  );

  modport slave (
    input  busy_in,
    input  opcode_in,
    input  lhs_in,
    input  rhs_in,
    input  rd_tag_in,
    output done_out,
    output value_out,
    output tag_out
  );
endinterface

// File: rtl/alu_unit.sv
// Two-stage integer ALU: S1 latches operands, S2 registers the result.
// Global ready freezes everything; clear flushes both stages.
module alu_unit #(
  parameter int ROB_WIDTH = 4
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     clear_signal,
  alu_unit_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_EQ   = 4'd10,
    OP_NE   = 4'd11,
    OP_LT   = 4'd12,
    OP_GE   = 4'd13,
    OP_LTU  = 4'd14,
    OP_GEU  = 4'd15
  } op_e;

  logic                 s1_valid;
  op_e                  s1_op;
  logic [31:0]          s1_lhs;
  logic [31:0]          s1_rhs;
  logic [ROB_WIDTH-1:0] s1_tag;

  logic                 s2_valid;
  logic [31:0]          s2_value;
  logic [ROB_WIDTH-1:0] s2_tag;

  logic [31:0] result;
  logic [4:0]  shamt;
  logic        lt_s;
  logic        lt_u;
  logic        eq;

  assign shamt = s1_rhs[4:0];
  assign lt_s  = $signed(s1_lhs) < $signed(s1_rhs);
  assign lt_u  = s1_lhs < s1_rhs;
  assign eq    = s1_lhs == s1_rhs;

  always_comb begin
    result = '0;
    unique case (s1_op)
      OP_ADD:  result = s1_lhs + s1_rhs;
      OP_SUB:  result = s1_lhs - s1_rhs;
      OP_SLL:  result = s1_lhs << shamt;
      OP_SLT:  result = {31'd0, lt_s};
      OP_SLTU: result = {31'd0, lt_u};
      OP_XOR:  result = s1_lhs ^ s1_rhs;
      OP_SRL:  result = s1_lhs >> shamt;
      OP_SRA:  result = $signed(s1_lhs) >>> shamt;
      OP_OR:   result = s1_lhs | s1_rhs;
      OP_AND:  result = s1_lhs & s1_rhs;
      OP_EQ:   result = {31'd0, eq};
      OP_NE:   result = {31'd0, !eq};
      OP_LT:   result = {31'd0, lt_s};
      OP_GE:   result = {31'd0, !lt_s};
      OP_LTU:  result = {31'd0, lt_u};
      OP_GEU:  result = {31'd0, !lt_u};
    endcase
  end

  // Payload registers only load alongside a valid bit.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_lhs   <= '0;
      s1_rhs   <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_value <= '0;
      s2_tag   <= '0;
    end else if (rdy_in) begin
      if (clear_signal) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        s1_valid <= bus.busy_in;
        s2_valid <= s1_valid;
        if (bus.busy_in) begin
          s1_op  <= op_e'(bus.opcode_in);
          s1_lhs <= bus.lhs_in;
          s1_rhs <= bus.rhs_in;
          s1_tag <= bus.rd_tag_in;
        end
        if (s1_valid) begin
          s2_value <= result;
          s2_tag   <= s1_tag;
        end
      end
    end
  end

  assign bus.done_out  = s2_valid;
  assign bus.value_out = s2_value;
  assign bus.tag_out   = s2_tag;

endmodule
